// File: rtl/tetromino_bag_scheduler_if.sv
// Consumer-facing bundle of the tetromino bag scheduler: random input,
// game control, pop request and the head/preview/bag status outputs.
interface tetromino_bag_scheduler_if #(
  parameter int PREVIEW_DEPTH = 3
);
  logic [2:0]                 rand_bits;
  logic                       new_game;
  logic                       piece_req;
  logic                       piece_valid;
  logic [2:0]                 piece_out;
  logic [3*PREVIEW_DEPTH-1:0] preview;
  logic [2:0]                 bag_remaining;

  modport master (
    output rand_bits, new_game, piece_req,
    input  piece_valid, piece_out, preview, bag_remaining
  );

  modport slave (
    input  rand_bits, new_game, piece_req,
    output piece_valid, piece_out, preview, bag_remaining
  );
endinterface

// File: rtl/tetromino_bag_scheduler.sv
// 7-bag tetromino scheduler: draws random pieces without repetition inside a
// bag, falls back to the lowest unused piece after MAX_REJECT consecutive
// rejected draws, and keeps a head + PREVIEW_DEPTH preview FIFO.
module tetromino_bag_scheduler #(
  parameter int PREVIEW_DEPTH = 3,
  parameter int MAX_REJECT    = 15
) (
  input logic                     clk,
  input logic                     rst_l,
  tetromino_bag_scheduler_if.slave bus
);
  localparam int D  = PREVIEW_DEPTH + 1;
  localparam int CW = $clog2(D + 1);
  localparam int RW = $clog2(MAX_REJECT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(D);
  localparam logic [RW-1:0] MAXREJ_C = RW'(MAX_REJECT);

  logic [2:0]    fifo_q [D];
  logic [2:0]    fifo_d [D];
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    used_q, used_d;
  logic [RW-1:0] rej_q, rej_d;

  logic          pop_s, draw_s, accept_s;
  logic [2:0]    pick_s;
  logic [6:0]    used_set_s;
  logic [7:0]    used_ext_s;
  logic [CW-1:0] tail_s;

  // Lowest-numbered piece whose used bit is still clear (0 if none).
  function automatic logic [2:0] lowest_unused(input logic [6:0] used);
    logic [2:0] p;
    p = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (!used[k]) p = 3'(k + 1);
    end
    return p;
  endfunction

  // Number of set bits in the used mask.
  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 0; k < 7; k++) c = c + {2'b00, v[k]};
    return c;
  endfunction

  // Draw decision, FIFO shift/append and next bag/reject state.
  always_comb begin
    pop_s      = bus.piece_req && (count_q != '0);
    draw_s     = (count_q < DEPTH_C) || pop_s;
    // Bit 0 stands in for "piece 0", which is never acceptable.
    used_ext_s = {used_q, 1'b1};
    pick_s     = 3'd0;
    accept_s   = 1'b0;
    if (rej_q == MAXREJ_C) begin
      pick_s   = lowest_unused(used_q);
      accept_s = draw_s;
    end else if (!used_ext_s[bus.rand_bits]) begin
      pick_s   = bus.rand_bits;
      accept_s = draw_s;
    end else begin
      pick_s   = 3'd0;
      accept_s = 1'b0;
    end

    used_set_s = used_q;
    for (int k = 0; k < 7; k++) begin
      if (pick_s == 3'(k + 1)) used_set_s[k] = 1'b1;
    end

    for (int i = 0; i < D; i++) fifo_d[i] = fifo_q[i];
    if (pop_s) begin
      for (int i = 0; i < D - 1; i++) fifo_d[i] = fifo_q[i + 1];
      fifo_d[D-1] = 3'd0;
      tail_s      = count_q - CW'(1);
    end else begin
      tail_s      = count_q;
    end
    if (accept_s) begin
      for (int i = 0; i < D; i++) begin
        if (CW'(i) == tail_s) fifo_d[i] = pick_s;
      end
    end

    if (pop_s && !accept_s) begin
      count_d = count_q - CW'(1);
    end else if (accept_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end

    if (accept_s) begin
      rej_d  = '0;
      // A completed bag rolls straight over to an empty mask.
      used_d = (used_set_s == 7'h7F) ? 7'h00 : used_set_s;
    end else if (draw_s) begin
      rej_d  = rej_q + RW'(1);
      used_d = used_q;
    end else begin
      rej_d  = rej_q;
      used_d = used_q;
    end

    if (bus.new_game) begin
      for (int i = 0; i < D; i++) fifo_d[i] = 3'd0;
      count_d = '0;
      used_d  = 7'h00;
      rej_d   = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < D; i++) fifo_q[i] <= 3'd0;
      count_q <= '0;
      used_q  <= 7'h00;
      rej_q   <= '0;
    end else begin
      for (int i = 0; i < D; i++) fifo_q[i] <= fifo_d[i];
      count_q <= count_d;
      used_q  <= used_d;
      rej_q   <= rej_d;
    end
  end

  // Head, preview and bag status decoded from registered state.
  always_comb begin
    bus.piece_valid   = (count_q != '0);
    bus.piece_out     = (count_q != '0) ? fifo_q[0] : 3'd0;
    bus.bag_remaining = 3'd7 - popcount7(used_q);
    bus.preview       = '0;
    for (int i = 1; i < D; i++) begin
      if (CW'(i) < count_q) bus.preview[3*(i-1) +: 3] = fifo_q[i];
      else                  bus.preview[3*(i-1) +: 3] = 3'd0;
    end
  end
endmodule
